// File: rtl/serial_fs.sv
// Bit-serial full subtractor: computes a - b - bin LSB-first, one bit per clock,
// through a single full-subtractor cell and a borrow flip-flop, behind valid/ready handshakes.
module serial_fs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, diff_q;
  logic [CntW-1:0]   cnt_q;
  logic              br_q, bout_q, done_valid_q, busy_q;

  logic              bit_a, bit_b, cell_d, cell_br;

  // The single full-subtractor cell, fed from bit 0 of the operand shift registers.
  always_comb begin
    bit_a   = a_q[0];
    bit_b   = b_q[0];
    cell_d  = bit_a ^ bit_b ^ br_q;
    cell_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      bout_q       <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            br_q    <= bin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // LSB-first fill: after WIDTH shifts bit 0 of the result sits at diff_q[0].
          diff_q <= {cell_d, diff_q[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= cell_br;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            bout_q       <= cell_br;
            done_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          if (done_ready_i) begin
            done_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign start_ready_o = (state_q == StIdle);
  assign diff_o        = diff_q;
  assign bout_o        = bout_q;
  assign done_valid_o  = done_valid_q;
  assign busy_o        = busy_q;

endmodule
